a2d_scan_sched: RTL
===================

# a2d_scan_sched

Round-robin conversion scheduler that sits between the control logic and `A2D_intf`. It sequences `strt_cnv`/`chnnl` across a mask of enabled channels and stores each 12-bit result in a per-channel register file. It also grants one-shot host conversions ahead of the scan and guards every conversion with a completion timeout. Exactly one conversion is outstanding at any time.

## Interface
Parameters:
- `SCAN_GAP`, 16: idle cycles inserted after every conversion, whether it completed or timed out. Allowed range is 1..255.
- `TIMEOUT`, 1023: cycles to wait for `cnv_cmplt` before abandoning a conversion. Allowed range is 2..4095.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `en` in 1: scan enable.
- `chnl_mask` in 8: bit i set means channel i is part of the scan.
- `host_req` in 1: host conversion request, level. Held high until `host_ack`.
- `host_chnl` in 3: channel for the host request. Stable while `host_req` is high.
- `host_ack` out 1: one-cycle pulse when the host conversion ends.
- `host_res` out 12: result of the host conversion. Valid only during `host_ack`.
- `strt_cnv` out 1: one-cycle start pulse to `A2D_intf`.
- `chnnl` out 3: channel to `A2D_intf`. Registered and held from `strt_cnv` until the next `strt_cnv`.
- `cnv_cmplt` in 1: completion pulse from `A2D_intf`.
- `res` in 12: result from `A2D_intf`. Sampled in the `cnv_cmplt` cycle.
- `rd_chnl` in 3: read address into the result file.
- `rd_data` out 12: result stored for `rd_chnl`. Combinational read.
- `res_vld` out 8: bit i means channel i holds a result.
- `tmo_err` out 8: sticky per-channel timeout flags.
- `scan_done` out 1: one-cycle pulse at the end of each scan pass.
- `busy` out 1: high in every state except IDLE.

## Operation
States: IDLE, START, WAIT, GAP.

- **IDLE**
  - Go to START when `host_req` is high and no host request is latched.
  - Also go to START when `en` is high and `chnl_mask` is non-zero.
- **START** (1 cycle)
  - Select the channel:
    - A pending host request wins. Latch `host_chnl` and set the internal `host_inflt` flag.
    - Otherwise take the first set mask bit scanning upward from `ptr+1` mod 8, wrapping around. Set `ptr` to that channel.
  - Register `chnnl`, pulse `strt_cnv`, clear the timeout counter, then go to WAIT.
- **WAIT**
  - The timeout counter increments every cycle.
  - On `cnv_cmplt`:
    - Write `res` to `rf[chnnl]`, set `res_vld[chnnl]`, clear `tmo_err[chnnl]`.
    - If `host_inflt`: pulse `host_ack`, drive `host_res = res`, clear `host_inflt`.
    - If this was a scan conversion and no set mask bit lies above `chnnl`: pulse `scan_done`.
    - Go to GAP.
  - On the counter reaching `TIMEOUT-1` without `cnv_cmplt`:
    - Set `tmo_err[chnnl]`. Leave `res_vld` and `rf` unchanged.
    - A host conversion still pulses `host_ack`, with `host_res = 12'h000`.
    - `scan_done` still applies, using the same rule as completion.
    - Go to GAP.
  - `cnv_cmplt` wins when it arrives in the same cycle as the timeout.
- **GAP**
  - Count `SCAN_GAP` cycles.
  - Then go to START if a host request is pending, or if `en` is high with a non-zero mask. Otherwise go to IDLE.

Rules that apply across states:
- `cnv_cmplt` outside WAIT is ignored.
- `chnl_mask` and `en` are sampled only at selection points, so changes take effect on the next selection.
- Deasserting `en` mid-conversion finishes the current conversion and its gap, then goes to IDLE.
- A host request is accepted even when `en` is low. `host_req` still high in the cycle after `host_ack` is treated as a new request.
- Reset mid-conversion returns to IDLE immediately. A late `cnv_cmplt` after reset is ignored.

## Timing
- Reset values:
  - Outputs: `strt_cnv`=0, `chnnl`=0, `host_ack`=0, `host_res`=0, `scan_done`=0, `busy`=0, `res_vld`=0, `tmo_err`=0.
  - Internal state: every `rf` entry is 0, `ptr`=7 (so the first scan selects the lowest enabled channel), `host_inflt`=0.
- IDLE to `strt_cnv`: the start condition is true in cycle N, and `strt_cnv` is high in cycle N+1.
- Result capture:
  - `cnv_cmplt` in cycle M makes `rd_data`, `res_vld`, `host_ack` and `scan_done` visible in cycle M+1.
  - The next `strt_cnv` comes no earlier than M+1+`SCAN_GAP`+1.
- Timeout: no `cnv_cmplt` means `tmo_err` is set `TIMEOUT` cycles after `strt_cnv`.
- Every output except `rd_data` is registered.

## Test plan
The bench uses a stub in place of `A2D_intf`: it answers `cnv_cmplt` 20 cycles after `strt_cnv` with `res` = 12'h100 + `chnnl`. Runs use `SCAN_GAP`=4 and `TIMEOUT`=50.

1. **Reset:** hold `rst_n`=0. All outputs must read 0. After release with `en`=0, `strt_cnv` must stay 0.
2. **Basic scan:** `en`=1, `chnl_mask`=8'b0000_1010.
   - Conversion order must be 1, 3, 1, 3.
   - `scan_done` must pulse after each channel-3 result.
   - Reading `rd_chnl`=3 must give 12'h103. `res_vld` must read 8'h0A.
3. **Host priority:** during channel-1 WAIT, raise `host_req` with `host_chnl`=6.
   - The next conversion must be channel 6.
   - `host_ack` must pulse with `host_res`=12'h106.
   - The scan must then resume with channel 3.
4. **Timeout:** the stub drops the completion for channel 3.
   - `tmo_err` must equal 8'h08 50 cycles after `strt_cnv`.
   - `rd_data` for channel 3 must keep its old value.
   - The next pass must complete channel 3 and clear bit 3 of `tmo_err`.
5. **Single channel and disable:** `chnl_mask`=8'h80 must give back-to-back channel-7 conversions spaced 20+1+4+1 cycles apart. Dropping `en` mid-WAIT must finish that conversion, then `busy` must fall after the gap.
6. **Reset mid-WAIT:** pulse `rst_n` low, then let the stub send `cnv_cmplt`.
   - `res_vld` must stay 0 and the state must stay IDLE.
   - The first scan after reset must start at the lowest enabled channel.

Source files
------------

// File: rtl/a2d_scan_sched.sv
// a2d_scan_sched
// Round-robin conversion scheduler in front of A2D_intf. Walks the enabled
// channels of chnl_mask, issues strt_cnv/chnnl, and stores each 12-bit result
// in a per-channel register file. One-shot host conversions are granted ahead
// of the scan. Every conversion is guarded by a completion timeout, and only
// one conversion is ever outstanding.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en, chnl_mask         scan enable and per-channel scan mask
//   host_req, host_chnl   level host request and its channel
//   host_ack, host_res    one-cycle host completion pulse and its result
//   strt_cnv, chnnl       start pulse and held channel to A2D_intf
//   cnv_cmplt, res        completion pulse and result from A2D_intf
//   rd_chnl, rd_data      combinational read port into the result file
//   res_vld, tmo_err      per-channel result-valid and sticky timeout flags
//   scan_done             one-cycle pulse at the end of each scan pass
//   busy                  high whenever the scheduler is not idle
module a2d_scan_sched #(
  parameter int SCAN_GAP = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  chnl_mask,
  input  logic        host_req,
  input  logic [2:0]  host_chnl,
  output logic        host_ack,
  output logic [11:0] host_res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_chnl,
  output logic [11:0] rd_data,
  output logic [7:0]  res_vld,
  output logic [7:0]  tmo_err,
  output logic        scan_done,
  output logic        busy
);

  localparam int          DATA_W   = 12;
  localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST = 8'(SCAN_GAP);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic              host_inflt;
  logic [7:0]        mask_q;
  logic [11:0]       tmo_cnt;
  logic [7:0]        gap_cnt;
  logic [DATA_W-1:0] rf [8];

  logic              start_req;
  logic              go;
  logic              sel_host;
  logic [2:0]        sel_chan;

  // First set mask bit strictly after 'from', wrapping; the pointer itself
  // is checked last. Iterating downward lets the nearest hit overwrite.
  function automatic logic [2:0] next_chan(input logic [7:0] mask,
                                           input logic [2:0] from);
    logic [2:0] sel;
    logic [2:0] idx;
    sel = from;
    for (int i = 8; i >= 1; i--) begin
      idx = from + 3'(i);
      if (mask[idx]) sel = idx;
    end
    return sel;
  endfunction

  // True when no enabled channel lies above ch, i.e. ch closes the pass.
  function automatic logic last_in_pass(input logic [7:0] mask,
                                        input logic [2:0] ch);
    logic [7:0] upper;
    upper = mask & ~((8'd2 << ch) - 8'd1);
    return (upper == 8'd0);
  endfunction

  always_comb begin
    sel_host  = host_req && !host_inflt;
    start_req = sel_host || (en && (chnl_mask != 8'd0));
    go        = start_req &&
                ((state == IDLE) || ((state == GAP) && (gap_cnt == GAP_LAST)));
    sel_chan  = sel_host ? host_chnl : next_chan(chnl_mask, ptr);
  end

  assign rd_data = rf[rd_chnl];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 3'd7;
      host_inflt <= 1'b0;
      mask_q     <= 8'd0;
      tmo_cnt    <= 12'd0;
      gap_cnt    <= 8'd0;
      strt_cnv   <= 1'b0;
      chnnl      <= 3'd0;
      host_ack   <= 1'b0;
      host_res   <= 12'd0;
      scan_done  <= 1'b0;
      busy       <= 1'b0;
      res_vld    <= 8'd0;
      tmo_err    <= 8'd0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      strt_cnv  <= 1'b0;
      host_ack  <= 1'b0;
      scan_done <= 1'b0;

      case (state)
        START: begin
          // Count from the strt_cnv cycle so the timeout lands exactly
          // TIMEOUT cycles after the start pulse.
          state   <= WAIT;
          tmo_cnt <= 12'd1;
        end
        WAIT: begin
          if (cnv_cmplt || (tmo_cnt == TMO_LAST)) begin
            state   <= GAP;
            gap_cnt <= 8'd0;
            if (cnv_cmplt) begin
              rf[chnnl]      <= res;
              res_vld[chnnl] <= 1'b1;
              tmo_err[chnnl] <= 1'b0;
            end else begin
              tmo_err[chnnl] <= 1'b1;
            end
            if (host_inflt) begin
              host_ack   <= 1'b1;
              host_res   <= cnv_cmplt ? res : 12'h000;
              host_inflt <= 1'b0;
            end else if (last_in_pass(mask_q, chnnl)) begin
              scan_done <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 12'd1;
          end
        end
        GAP: begin
          if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + 8'd1;
          end else if (!go) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase

      // Selection point: the channel is chosen on the edge into START so
      // strt_cnv and chnnl are already registered during START.
      if (go) begin
        state    <= START;
        busy     <= 1'b1;
        strt_cnv <= 1'b1;
        chnnl    <= sel_chan;
        tmo_cnt  <= 12'd0;
        mask_q   <= chnl_mask;
        if (sel_host) host_inflt <= 1'b1;
        else          ptr        <= sel_chan;
      end
    end
  end

endmodule
